// File: rtl/stream_mux.sv
// stream_mux: N-channel valid/ready stream multiplexer with one registered
// output stage. Channel choice is either driven by `sel` (MODE=0) or by a
// round-robin arbiter (MODE=1).
module stream_mux #(
    parameter int WIDTH = 32,
    parameter int N     = 4,
    parameter int SEL_W = $clog2(N),
    parameter int MODE  = 0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N*WIDTH-1:0] in_data,
    input  logic [N-1:0]       in_valid,
    output logic [N-1:0]       in_ready,
    input  logic [SEL_W-1:0]   sel,
    output logic [WIDTH-1:0]   out_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [SEL_W-1:0]   out_src,
    output logic               sel_err
);

    localparam int             NM1   = N - 1;
    localparam logic [SEL_W:0] N_EXT = N[SEL_W:0];
    localparam logic [SEL_W-1:0] LAST = NM1[SEL_W-1:0];

    logic [SEL_W-1:0] ptr;
    logic             load_ok;
    logic             sel_ok;
    logic [N-1:0]     grant;
    logic [SEL_W-1:0] grant_idx;
    logic             grant_any;
    logic [WIDTH-1:0] grant_data;
    logic             xfer;
    logic             sel_err_next;

    assign load_ok      = !out_valid | out_ready;
    assign sel_ok       = ({1'b0, sel} < N_EXT);
    assign in_ready     = {N{load_ok & !rst}} & grant;
    assign xfer         = load_ok & grant_any;
    assign sel_err_next = (MODE == 0) && !sel_ok && (|in_valid) && load_ok;

    // Pick at most one channel: explicit select, or first valid from ptr onward.
    always_comb begin
        logic [SEL_W:0] sum;
        grant     = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        sum       = '0;
        if (MODE == 0) begin
            if (sel_ok && in_valid[sel]) begin
                grant[sel] = 1'b1;
                grant_idx  = sel;
                grant_any  = 1'b1;
            end
        end else begin
            for (int unsigned k = 0; k < N; k++) begin
                // ptr < N always, so one conditional subtract gives (ptr + k) mod N
                sum = {1'b0, ptr} + (SEL_W+1)'(k);
                if (sum >= N_EXT) sum = sum - N_EXT;
                if (!grant_any && in_valid[sum[SEL_W-1:0]]) begin
                    grant[sum[SEL_W-1:0]] = 1'b1;
                    grant_idx             = sum[SEL_W-1:0];
                    grant_any             = 1'b1;
                end
            end
        end
    end

    // Route the granted channel's data towards the output register.
    always_comb begin
        grant_data = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (grant[i]) grant_data = in_data[i*WIDTH +: WIDTH];
        end
    end

    // Output register, error pulse and round-robin pointer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_data  <= '0;
            out_src   <= '0;
            out_valid <= 1'b0;
            sel_err   <= 1'b0;
            ptr       <= '0;
        end else begin
            sel_err <= sel_err_next;
            if (xfer) begin
                out_data  <= grant_data;
                out_src   <= grant_idx;
                out_valid <= 1'b1;
                if (MODE == 1) ptr <= (grant_idx == LAST) ? '0 : grant_idx + 1'b1;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_stream_mux.sv
// Testbench for stream_mux: three instances (MODE0/N4, MODE1/N4, MODE0/N3)
// checked every cycle against a transaction-level model, plus directed
// literal expectations.
module tb_stream_mux;

    logic clk;
    logic rst;

    logic [127:0] a_data;  logic [3:0] a_valid, a_ready;  logic [1:0] a_sel, a_src;
    logic [31:0]  a_odata; logic a_ovalid, a_ordy, a_err;
    logic [127:0] b_data;  logic [3:0] b_valid, b_ready;  logic [1:0] b_sel, b_src;
    logic [31:0]  b_odata; logic b_ovalid, b_ordy, b_err;
    logic [95:0]  c_data;  logic [2:0] c_valid, c_ready;  logic [1:0] c_sel, c_src;
    logic [31:0]  c_odata; logic c_ovalid, c_ordy, c_err;

    int checks = 0;
    int errors = 0;

    stream_mux #(.WIDTH(32), .N(4), .MODE(0)) dut_a (
        .clk(clk), .rst(rst), .in_data(a_data), .in_valid(a_valid), .in_ready(a_ready),
        .sel(a_sel), .out_data(a_odata), .out_valid(a_ovalid), .out_ready(a_ordy),
        .out_src(a_src), .sel_err(a_err));

    stream_mux #(.WIDTH(32), .N(4), .MODE(1)) dut_b (
        .clk(clk), .rst(rst), .in_data(b_data), .in_valid(b_valid), .in_ready(b_ready),
        .sel(b_sel), .out_data(b_odata), .out_valid(b_ovalid), .out_ready(b_ordy),
        .out_src(b_src), .sel_err(b_err));

    stream_mux #(.WIDTH(32), .N(3), .MODE(0)) dut_c (
        .clk(clk), .rst(rst), .in_data(c_data), .in_valid(c_valid), .in_ready(c_ready),
        .sel(c_sel), .out_data(c_odata), .out_valid(c_ovalid), .out_ready(c_ordy),
        .out_src(c_src), .sel_err(c_err));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // ---------------- accessors per instance ----------------
    function automatic int mode_of(int k); return (k == 1) ? 1 : 0; endfunction
    function automatic int n_of(int k);    return (k == 2) ? 3 : 4; endfunction

    function automatic logic [15:0] vld(int k);
        case (k)
            0: return {12'b0, a_valid};
            1: return {12'b0, b_valid};
            default: return {13'b0, c_valid};
        endcase
    endfunction
    function automatic int sel_of(int k);
        case (k)
            0: return int'(a_sel);
            1: return int'(b_sel);
            default: return int'(c_sel);
        endcase
    endfunction
    function automatic logic ordy_of(int k);
        case (k)
            0: return a_ordy;
            1: return b_ordy;
            default: return c_ordy;
        endcase
    endfunction
    function automatic logic [31:0] dat(int k, int i);
        case (k)
            0: return a_data[i*32 +: 32];
            1: return b_data[i*32 +: 32];
            default: return c_data[i*32 +: 32];
        endcase
    endfunction
    function automatic logic [31:0] dut_ready(int k);
        case (k)
            0: return 32'(a_ready);
            1: return 32'(b_ready);
            default: return 32'(c_ready);
        endcase
    endfunction
    function automatic logic [31:0] dut_valid(int k);
        case (k)
            0: return 32'(a_ovalid);
            1: return 32'(b_ovalid);
            default: return 32'(c_ovalid);
        endcase
    endfunction
    function automatic logic [31:0] dut_data(int k);
        case (k)
            0: return a_odata;
            1: return b_odata;
            default: return c_odata;
        endcase
    endfunction
    function automatic logic [31:0] dut_src(int k);
        case (k)
            0: return 32'(a_src);
            1: return 32'(b_src);
            default: return 32'(c_src);
        endcase
    endfunction
    function automatic logic [31:0] dut_err(int k);
        case (k)
            0: return 32'(a_err);
            1: return 32'(b_err);
            default: return 32'(c_err);
        endcase
    endfunction

    // ---------------- behavioural model ----------------
    logic        m_valid [3];
    logic [31:0] m_data  [3];
    int          m_src   [3];
    logic        m_err   [3];
    int          m_ptr   [3];

    // Channel that wins this cycle, or -1 when nobody is granted.
    function automatic int grant_of(int mode, int n, int s, logic [15:0] v, int p);
        if (mode == 0) return (s < n && v[s]) ? s : -1;
        for (int off = 0; off < n; off++) begin
            if (v[(p + off) % n]) return (p + off) % n;
        end
        return -1;
    endfunction

    function automatic int model_grant(int k);
        return grant_of(mode_of(k), n_of(k), sel_of(k), vld(k), m_ptr[k]);
    endfunction

    task automatic model_step(input int k);
        logic lok;
        int   g;
        lok = !m_valid[k] || ordy_of(k);
        g   = model_grant(k);
        m_err[k] = (mode_of(k) == 0) && (sel_of(k) >= n_of(k)) && (vld(k) != 0) && lok;
        if (lok && g >= 0) begin
            m_data[k]  = dat(k, g);
            m_src[k]   = g;
            m_valid[k] = 1'b1;
            if (mode_of(k) == 1) m_ptr[k] = (g + 1) % n_of(k);
        end else if (ordy_of(k)) begin
            m_valid[k] = 1'b0;
        end
    endtask

    // Advance the model on every clock edge; reset clears it immediately.
    always @(posedge clk or posedge rst) begin
        for (int k = 0; k < 3; k++) begin
            if (rst) begin
                m_valid[k] = 1'b0; m_data[k] = '0; m_src[k] = 0; m_err[k] = 1'b0; m_ptr[k] = 0;
            end else begin
                model_step(k);
            end
        end
    end

    // Compare every instance against the model away from the active edge.
    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            logic [31:0] exp_rdy;
            int g;
            g = model_grant(k);
            exp_rdy = (!rst && (!m_valid[k] || ordy_of(k)) && g >= 0) ? (32'd1 << g) : 32'd0;
            check($sformatf("i%0d in_ready", k), dut_ready(k), exp_rdy);
            check($sformatf("i%0d out_valid", k), dut_valid(k), 32'(m_valid[k]));
            check($sformatf("i%0d out_data", k), dut_data(k), m_data[k]);
            check($sformatf("i%0d out_src", k), dut_src(k), 32'(m_src[k]));
            check($sformatf("i%0d sel_err", k), dut_err(k), 32'(m_err[k]));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    int rr_a [8] = '{0, 1, 2, 3, 0, 1, 2, 3};
    int rr_b [4] = '{1, 3, 1, 3};

    // Directed stimulus with hand-computed expectations.
    initial begin
        a_data = '0; a_valid = '0; a_sel = '0; a_ordy = 1'b1;
        b_data = '0; b_valid = '0; b_sel = '0; b_ordy = 1'b1;
        c_data = '0; c_valid = '0; c_sel = '0; c_ordy = 1'b1;
        rst = 1'b0;
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        check("reset out_valid", 32'(a_ovalid), 32'd0);
        check("reset out_data", a_odata, 32'd0);
        check("reset out_src", 32'(a_src), 32'd0);
        check("reset sel_err", 32'(a_err), 32'd0);

        // asynchronous reset while a beat is held
        a_sel = 2'd0; a_valid = 4'b0001; a_data[31:0] = 32'h1111_1111; a_ordy = 1'b0;
        tick();
        check("held out_valid", 32'(a_ovalid), 32'd1);
        check("held out_data", a_odata, 32'h1111_1111);
        #2 rst = 1'b1;
        #1;
        check("async rst out_valid", 32'(a_ovalid), 32'd0);
        check("async rst out_data", a_odata, 32'd0);
        check("async rst out_src", 32'(a_src), 32'd0);
        check("async rst in_ready", 32'(a_ready), 32'd0);
        tick();
        rst = 1'b0; a_valid = '0; a_ordy = 1'b1;
        tick();

        // select path
        a_sel = 2'd2; a_valid = 4'b0100; a_data[95:64] = 32'hDEAD_BEEF;
        #1 check("sel2 in_ready", 32'(a_ready), 32'h4);
        tick();
        check("sel2 out_valid", 32'(a_ovalid), 32'd1);
        check("sel2 out_data", a_odata, 32'hDEAD_BEEF);
        check("sel2 out_src", 32'(a_src), 32'd2);
        a_sel = 2'd1;
        #1 check("sel1 invalid in_ready", 32'(a_ready), 32'd0);
        tick();
        check("sel1 drain out_valid", 32'(a_ovalid), 32'd0);
        check("sel1 keep out_src", 32'(a_src), 32'd2);
        a_valid = '0;

        // back-pressure
        a_sel = 2'd0; a_valid = 4'b0001; a_data[31:0] = 32'hA000_0001;
        tick();
        check("bp first beat", a_odata, 32'hA000_0001);
        a_ordy = 1'b0; a_data[31:0] = 32'hA000_0002;
        for (int j = 0; j < 5; j++) begin
            #1;
            check("bp stall in_ready", 32'(a_ready), 32'd0);
            check("bp stall out_data", a_odata, 32'hA000_0001);
            tick();
        end
        a_ordy = 1'b1;
        #1 check("bp release in_ready", 32'(a_ready), 32'h1);
        tick();
        check("bp no bubble out_valid", 32'(a_ovalid), 32'd1);
        check("bp no bubble out_data", a_odata, 32'hA000_0002);
        a_valid = '0;
        tick();

        // round-robin fairness
        for (int i = 0; i < 4; i++) b_data[i*32 +: 32] = 32'hB0 + 32'(i);
        b_valid = 4'b1111; b_ordy = 1'b1;
        for (int j = 0; j < 8; j++) begin
            tick();
            check("rr all out_src", 32'(b_src), 32'(rr_a[j]));
            check("rr all out_data", b_odata, 32'hB0 + 32'(rr_a[j]));
        end
        b_valid = 4'b1010;
        for (int j = 0; j < 4; j++) begin
            tick();
            check("rr 1/3 out_src", 32'(b_src), 32'(rr_b[j]));
        end
        b_valid = '0;
        tick();
        check("rr idle out_valid", 32'(b_ovalid), 32'd0);

        // out-of-range select on N=3
        for (int i = 0; i < 3; i++) c_data[i*32 +: 32] = 32'hC0 + 32'(i);
        c_sel = 2'd3; c_valid = 3'b111; c_ordy = 1'b1;
        #1 check("oor in_ready", 32'(c_ready), 32'd0);
        tick();
        check("oor sel_err", 32'(c_err), 32'd1);
        check("oor out_valid", 32'(c_ovalid), 32'd0);
        c_valid = '0;
        tick();
        check("oor sel_err clears", 32'(c_err), 32'd0);
        c_sel = 2'd2; c_valid = 3'b100;
        tick();
        check("n3 sel2 out_src", 32'(c_src), 32'd2);
        check("n3 sel2 out_data", c_odata, 32'hC2);
        c_valid = '0;
        tick();

        // reset during a stall in round-robin mode
        b_ordy = 1'b0; b_valid = 4'b0100;
        tick();
        check("stall ch2 out_src", 32'(b_src), 32'd2);
        b_valid = 4'b0101;
        #1 check("stall in_ready", 32'(b_ready), 32'd0);
        tick();
        check("stall hold out_data", b_odata, 32'hB2);
        #2 rst = 1'b1;
        #1;
        check("stall rst out_valid", 32'(b_ovalid), 32'd0);
        check("stall rst in_ready", 32'(b_ready), 32'd0);
        tick();
        rst = 1'b0; b_ordy = 1'b1;
        #1 check("post rst in_ready", 32'(b_ready), 32'h1);
        tick();
        check("post rst out_src", 32'(b_src), 32'd0);
        check("post rst out_data", b_odata, 32'hB0);
        b_valid = '0;
        tick();
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
